// File: rtl/imem_fetch_sequencer_pkg.sv
// imem_fetch_sequencer_pkg
//   Shared types and constants for the instruction fetch sequencer:
//   FSM state encoding, fetch queue entry layout, PC step, NOP word and
//   the illegal-PC predicate.
package imem_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_W  = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h2000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // limit is 4*IMEM_WORDS, carried at 33 bits so it cannot wrap.
  function automatic logic pc_illegal(input logic [31:0] pc, input logic [32:0] limit);
    return (pc[1:0] != 2'b00) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/imem_fetch_sequencer_fetch_queue.sv
// fetch_queue
//   Circular FIFO, DEPTH entries (power of two, >= 2) of WIDTH bits.
//   Pointers carry an extra wrap bit; full/empty come from pointer compare.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     flush              empties the queue (wins over push/pop)
//     push, wdata        write; accepted when not full or when popping
//     pop                read advance; ignored when empty
//     rdata              head entry (stale when empty)
//     full, empty, count occupancy status
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count   = wr_q - rd_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer
//   Owns the PC, addresses the combinational instruction memory and queues
//   {PC, instruction} pairs for decode over a valid/ready handshake.
//   Handles start, halt/drain, branch redirect with flush and illegal-PC fault.
//   Optional macro FETCH_PERF_CNT_EN adds saturating FetchCount/StallCount.
//   Ports:
//     Clk, Rst_n             clock, asynchronous active-low reset
//     Start                  pulse: restart fetching from RESET_PC
//     Halt                   level: stop fetching, drain queue
//     Redirect, RedirectPC   pulse + target: flush and refetch at target
//     IMemAddr / IMemData    instruction memory address / word
//     InstrValid/Instr/InstrPC/InstrReady  decode handshake (queue head)
//     Busy                   state != IDLE
//     Fault                  sticky illegal-PC flag
//     FetchCount/StallCount  (FETCH_PERF_CNT_EN only) pushes / full-stall cycles
module imem_fetch_sequencer
  import imem_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Halt,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        InstrReady,
  output logic        Busy,
  output logic        Fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  localparam int unsigned QAW      = $clog2(QDEPTH) + 1;
  localparam logic [32:0] PC_LIMIT = {1'b0, 32'(IMEM_WORDS)} << 2;

  fetch_state_e   state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic           fault_q, fault_d;
  logic           start_go;
  logic           q_push, q_pop, q_flush, q_full, q_empty;
  logic [QAW-1:0] q_count;
  fetch_entry_t   q_wdata, q_rdata;

  fetch_queue #(
    .DEPTH(QDEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_queue (
    .clk   (Clk),
    .rst_n (Rst_n),
    .flush (q_flush),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    fault_d        = fault_q;
    start_go       = 1'b0;
    q_flush        = 1'b0;
    q_push         = 1'b0;
    q_pop          = !q_empty && InstrReady;
    q_wdata.pc     = pc_q;
    q_wdata.instr  = IMemData;

    if (Redirect && (state_q == S_FETCH || state_q == S_DRAIN)) begin
      q_flush = 1'b1;
      pc_d    = RedirectPC;
      state_d = S_FETCH;
    end else if (Start) begin
      q_flush  = 1'b1;
      pc_d     = RESET_PC;
      fault_d  = 1'b0;
      start_go = 1'b1;
      state_d  = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (Halt) begin
            state_d = S_DRAIN;
          end else if (!q_full || q_pop) begin
            // PC legality is judged only when a push would actually happen.
            if (pc_illegal(pc_q, PC_LIMIT)) begin
              fault_d = 1'b1;
              q_flush = 1'b1;
              state_d = S_FAULT;
            end else begin
              q_push = 1'b1;
              pc_d   = pc_q + PC_STEP;
            end
          end
        end
        S_DRAIN: begin
          if (!Halt) begin
            state_d = S_FETCH;
          end else if (q_empty || (q_pop && q_count == QAW'(1))) begin
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign IMemAddr   = pc_q;
  assign InstrValid = !q_empty;
  assign Instr      = q_empty ? '0 : q_rdata.instr;
  assign InstrPC    = q_empty ? '0 : q_rdata.pc;
  assign Busy       = (state_q != S_IDLE);
  assign Fault      = fault_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (start_go) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (q_push && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == S_FETCH && q_full && !q_pop && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
module tb_imem_fetch_sequencer;

  localparam logic [31:0] RESET_PC   = 32'd0;
  localparam int          IMEM_WORDS = 256;
  localparam int          QD         = 2;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DRAIN = 2;
  localparam int M_FAULT = 3;

  logic        Clk = 1'b0;
  logic        Rst_n, Start, Halt, Redirect, InstrReady;
  logic [31:0] RedirectPC, IMemAddr, IMemData, Instr, InstrPC;
  logic        InstrValid, Busy, Fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount, StallCount;
`endif

  logic [31:0] mem [IMEM_WORDS];

  always #5 Clk = ~Clk;

  assign IMemData = (IMemAddr < 32'd1024) ? mem[IMemAddr[9:2]] : 32'hdead_beef;

  imem_fetch_sequencer #(
    .RESET_PC  (RESET_PC),
    .IMEM_WORDS(IMEM_WORDS),
    .QDEPTH    (QD)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Halt      (Halt),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .IMemAddr  (IMemAddr),
    .IMemData  (IMemData),
    .InstrValid(InstrValid),
    .Instr     (Instr),
    .InstrPC   (InstrPC),
    .InstrReady(InstrReady),
    .Busy      (Busy),
    .Fault     (Fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount(FetchCount),
    .StallCount(StallCount)
`endif
  );

  // Reference model: a queue of {pc, instr} pairs plus mode/PC/fault.
  logic [63:0] mq[$];
  int          mode;
  logic [31:0] mpc;
  bit          mfault;
  logic [31:0] mfetch, mstall;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit illegal(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc >= 32'(4 * IMEM_WORDS));
  endfunction

  task automatic model_reset();
    mq.delete();
    mode   = M_IDLE;
    mpc    = RESET_PC;
    mfault = 0;
    mfetch = 0;
    mstall = 0;
  endtask

  task automatic model_step();
    bit pop;
    pop = (mq.size() > 0) && InstrReady;
    if (mode == M_FETCH && mq.size() == QD && !pop && mstall != 32'hffff_ffff) mstall++;
    if (Redirect && (mode == M_FETCH || mode == M_DRAIN)) begin
      mq.delete();
      mpc  = RedirectPC;
      mode = M_FETCH;
    end else if (Start) begin
      mq.delete();
      mpc    = RESET_PC;
      mfault = 0;
      mode   = M_FETCH;
      mfetch = 0;
      mstall = 0;
    end else if (mode == M_FETCH) begin
      if (Halt) begin
        if (pop) void'(mq.pop_front());
        mode = M_DRAIN;
      end else if (mq.size() < QD || pop) begin
        if (illegal(mpc)) begin
          mq.delete();
          mfault = 1;
          mode   = M_FAULT;
        end else begin
          if (pop) void'(mq.pop_front());
          mq.push_back({mpc, mem[mpc[9:2]]});
          mpc = mpc + 32'd4;
          if (mfetch != 32'hffff_ffff) mfetch++;
        end
      end
    end else if (mode == M_DRAIN) begin
      if (pop) void'(mq.pop_front());
      if (!Halt) mode = M_FETCH;
      else if (mq.size() == 0) mode = M_IDLE;
    end
  endtask

  task automatic check_outputs();
    logic [63:0] h;
    bit v;
    v = (mq.size() > 0);
    h = v ? mq[0] : 64'd0;
    check("valid",  32'(InstrValid), 32'(v));
    check("instr",  Instr, h[31:0]);
    check("ipc",    InstrPC, h[63:32]);
    check("addr",   IMemAddr, mpc);
    check("busy",   32'(Busy), 32'(mode != M_IDLE));
    check("fault",  32'(Fault), 32'(mfault));
`ifdef FETCH_PERF_CNT_EN
    check("fetchcnt", FetchCount, mfetch);
    check("stallcnt", StallCount, mstall);
`endif
  endtask

  task automatic cycle(input bit st, input bit hl, input bit rd, input bit rdy,
                       input logic [31:0] rpc);
    @(negedge Clk);
    Start      = st;
    Halt       = hl;
    Redirect   = rd;
    InstrReady = rdy;
    RedirectPC = rpc;
    model_step();
    @(posedge Clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, input bit hl, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, hl, 1'b0, rdy, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    Start = 1'b0; Halt = 1'b0; Redirect = 1'b0; InstrReady = 1'b0; RedirectPC = '0;
    #1;
    model_reset();
    check_outputs();
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit hl;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom();
    Rst_n = 1'b0; Start = 1'b0; Halt = 1'b0; Redirect = 1'b0;
    InstrReady = 1'b0; RedirectPC = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge Clk);
    Rst_n = 1'b1;

    // Straight-line run, decode always ready.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    check("start_not_yet_valid", 32'(InstrValid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    check("first_pc", InstrPC, 32'd0);
    run(22, 1'b0, 1'b1);

    // Backpressure: queue holds PC 0 and 4, fetch address parks at 8.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    run(5, 1'b0, 1'b0);
    check("stall_addr", IMemAddr, 32'd8);
    run(6, 1'b0, 1'b1);

    // Redirect to 20 while the queue holds 12,16.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    run(3, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd12);
    run(3, 1'b0, 1'b0);
    check("q_head_12", InstrPC, 32'd12);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'd20);
    check("redir_flush", 32'(InstrValid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    check("redir_target", InstrPC, 32'd20);
    run(4, 1'b0, 1'b1);

    // Misaligned redirect target faults; Start recovers.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'd6);
    run(3, 1'b0, 1'b1);
    check("fault_misaligned", 32'(Fault), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    run(3, 1'b0, 1'b1);

    // Running off the end of memory faults at 1024.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'd1012);
    run(6, 1'b0, 1'b1);
    check("fault_end", 32'(Fault), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    run(2, 1'b0, 1'b1);

    // Halt with a full queue drains two entries then idles.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    run(3, 1'b0, 1'b0);
    run(4, 1'b1, 1'b1);
    check("halt_idle", 32'(Busy), 32'd0);
    run(2, 1'b0, 1'b1);

    // Asynchronous reset in the middle of fetching.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    run(4, 1'b0, 1'b1);
    do_reset();

`ifdef FETCH_PERF_CNT_EN
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    run(12, 1'b0, 1'b0);
    check("perf_fetch", FetchCount, 32'd2);
    check("perf_stall", StallCount, 32'd10);
`endif

    // Randomized traffic.
    hl = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      bit st, rd, rdy;
      logic [31:0] tgt;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        hl = 1'b0;
        continue;
      end
      st  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) hl = ~hl;
      rd  = ($urandom_range(0, 11) == 0);
      tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 7) == 0) tgt = $urandom();
      rdy = ($urandom_range(0, 9) < 7);
      cycle(st, hl, rd, rdy, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
